// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO with registered read data and full/empty/almost flags.
//
// Ports:
//    clk         : clock, everything updates on the rising edge
//    rstn        : synchronous reset, ACTIVE HIGH (legacy name kept)
//    i_wren      : write request
//    i_rden      : read request
//    i_wrdata    : write data, DATA_W bits
//    o_full      : count == DEPTH
//    o_empty     : count == 0
//    o_alm_full  : count >= DEPTH-ALM_FULL_OFS
//    o_alm_empty : count <= ALM_EMPTY_OFS
//    o_rddata    : registered read data, held until the next accepted read
//    o_ovf/o_udf : only with MODPORT_FIFO_ERR_EN defined; one-cycle pulses after a
//                  dropped write / an ignored read on empty
//
// Optional feature macro: MODPORT_FIFO_ERR_EN
module modport_fifo #(
   parameter int DATA_W        = 128,
   parameter int DEPTH         = 16,
   parameter int ALM_FULL_OFS  = 2,
   parameter int ALM_EMPTY_OFS = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_wren,
   input  logic              i_rden,
   input  logic [DATA_W-1:0] i_wrdata,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_alm_full,
   output logic              o_alm_empty,
   output logic [DATA_W-1:0] o_rddata
`ifdef MODPORT_FIFO_ERR_EN
   ,
   output logic              o_ovf,
   output logic              o_udf
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AF   = (AW+1)'(DEPTH - ALM_FULL_OFS);
   localparam logic [AW:0] CNT_AE   = (AW+1)'(ALM_EMPTY_OFS);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       count;
   logic              rd_acc;
   logic              wr_acc;
   always_comb begin
      o_full      = count == CNT_FULL;
      o_empty     = count == '0;
      o_alm_full  = count >= CNT_AF;
      o_alm_empty = count <= CNT_AE;
      rd_acc      = i_rden && !o_empty;
      // a read in the same cycle frees the slot, so a full FIFO still accepts the write
      wr_acc      = i_wren && (!o_full || rd_acc);
   end
   // storage is never cleared; reset only blocks the write
   always_ff @(posedge clk)
      if (wr_acc && !rstn) mem[wptr] <= i_wrdata;
   always_ff @(posedge clk) begin
      if (rstn) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         o_rddata <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) begin
            rptr     <= rptr + 1'b1;
            o_rddata <= mem[rptr];
         end
         count <= (wr_acc && !rd_acc) ? count + 1'b1 :
                  (rd_acc && !wr_acc) ? count - 1'b1 : count;
      end
   end
`ifdef MODPORT_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (rstn) begin
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else begin
         o_ovf <= i_wren && !wr_acc;
         o_udf <= i_rden && o_empty;
      end
   end
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: randomized and directed bench for modport_fifo against a queue model.
module tb_modport_fifo;
   localparam int DW = 128;
   localparam int DEPTH = 16;
   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          i_wren = 1'b0;
   logic          i_rden = 1'b0;
   logic [DW-1:0] i_wrdata = '0;
   logic          o_full, o_empty, o_alm_full, o_alm_empty;
   logic [DW-1:0] o_rddata;
`ifdef MODPORT_FIFO_ERR_EN
   logic          o_ovf, o_udf;
`endif
   modport_fifo dut (
      .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_rden(i_rden), .i_wrdata(i_wrdata),
      .o_full(o_full), .o_empty(o_empty), .o_alm_full(o_alm_full),
      .o_alm_empty(o_alm_empty), .o_rddata(o_rddata)
`ifdef MODPORT_FIFO_ERR_EN
      , .o_ovf(o_ovf), .o_udf(o_udf)
`endif
   );
   always #5 clk = ~clk;
   int errors = 0;
   int checks = 0;
   bit chk_en = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] rd_m = '0;
   bit ovf_m = 0;
   bit udf_m = 0;
   task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask
   // model: FIFO queue, read pops before write pushes so full+read+write works
   task automatic model(input bit rst, input bit wr, input bit rd, input logic [DW-1:0] d);
      bit can_rd, can_wr;
      if (rst) begin
         q.delete();
         rd_m = '0;
         ovf_m = 0;
         udf_m = 0;
      end else begin
         can_rd = q.size() > 0;
         can_wr = wr && (q.size() < DEPTH || (rd && can_rd));
         if (rd && can_rd) rd_m = q.pop_front();
         if (can_wr) q.push_back(d);
         ovf_m = wr && !can_wr;
         udf_m = rd && !can_rd;
      end
   endtask
   task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [DW-1:0] d);
      rstn = rst;
      i_wren = wr;
      i_rden = rd;
      i_wrdata = d;
      @(posedge clk);
      model(rst, wr, rd, d);
      #1;
   endtask
   always @(negedge clk) if (chk_en) begin
      chk("rddata", o_rddata, rd_m);
      chk("empty", DW'(o_empty), DW'(q.size() == 0));
      chk("full", DW'(o_full), DW'(q.size() == DEPTH));
      chk("alm_full", DW'(o_alm_full), DW'(q.size() >= DEPTH - 2));
      chk("alm_empty", DW'(o_alm_empty), DW'(q.size() <= 2));
`ifdef MODPORT_FIFO_ERR_EN
      chk("ovf", DW'(o_ovf), DW'(ovf_m));
      chk("udf", DW'(o_udf), DW'(udf_m));
`endif
   end
   initial begin
      bit ph, wr, rd;
      cyc(1, 1, 1, 128'h77);
      cyc(1, 0, 0, '0);
      chk_en = 1;
      chk("rst_empty", DW'(o_empty), 1);
      chk("rst_alm_empty", DW'(o_alm_empty), 1);
      chk("rst_full", DW'(o_full), 0);
      chk("rst_alm_full", DW'(o_alm_full), 0);
      chk("rst_rddata", o_rddata, 0);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 1, 0, DW'(k));
         if (k == 2) chk("fill_ae2", DW'(o_alm_empty), 1);
         if (k == 3) chk("fill_ae3", DW'(o_alm_empty), 0);
         if (k == 13) chk("fill_af13", DW'(o_alm_full), 0);
         if (k == 14) chk("fill_af14", DW'(o_alm_full), 1);
         if (k == 15) chk("fill_full15", DW'(o_full), 0);
      end
      chk("fill_full16", DW'(o_full), 1);
      cyc(0, 1, 0, 128'hDEAD);
      chk("ovf_full", DW'(o_full), 1);
`ifdef MODPORT_FIFO_ERR_EN
      chk("ovf_pulse", DW'(o_ovf), 1);
`endif
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 0, 1, '0);
         chk("drain_data", o_rddata, DW'(k));
      end
      chk("drain_empty", DW'(o_empty), 1);
      cyc(0, 0, 1, '0);
      chk("udf_hold", o_rddata, 128'h10);
      chk("udf_empty", DW'(o_empty), 1);
`ifdef MODPORT_FIFO_ERR_EN
      chk("udf_pulse", DW'(o_udf), 1);
`endif
      cyc(0, 1, 1, 128'hA5);
      chk("simul_empty_cnt", DW'(o_empty), 0);
      chk("simul_empty_hold", o_rddata, 128'h10);
      cyc(0, 0, 1, '0);
      chk("simul_empty_rd", o_rddata, 128'hA5);
      for (int k = 0; k < 16; k++) cyc(0, 1, 0, DW'(256 + k));
      cyc(0, 1, 1, 128'hBEEF);
      chk("simul_full_rd", o_rddata, 128'h100);
      chk("simul_full_full", DW'(o_full), 1);
      for (int k = 0; k < 16; k++) cyc(0, 0, 1, '0);
      chk("simul_full_last", o_rddata, 128'hBEEF);
      chk("simul_full_empty", DW'(o_empty), 1);
      for (int c = 0; c < 40; c++) begin
         ph = ((c / 5) % 2) == 1;
         wr = !ph || ($urandom % 4 == 0);
         rd = ph || ($urandom % 4 == 0);
         cyc(0, wr, rd, {$urandom, $urandom, $urandom, $urandom});
      end
      for (int c = 0; c < 400; c++)
         cyc(0, ($urandom % 100) < 55, ($urandom % 100) < 45,
             {$urandom, $urandom, $urandom, $urandom});
      cyc(1, 0, 0, '0);
      for (int k = 0; k < 7; k++) cyc(0, 1, 0, DW'(k + 32));
      cyc(1, 1, 1, 128'h99);
      chk("mid_rst_empty", DW'(o_empty), 1);
      chk("mid_rst_data", o_rddata, 0);
      cyc(0, 0, 1, '0);
      chk("mid_rst_rd_ignored", o_rddata, 0);
      chk("mid_rst_still_empty", DW'(o_empty), 1);
      @(negedge clk);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
